// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module      : register_file_32x32
// Description : General-purpose datapath register file. It holds 2**ADDR_W
//               registers of DATA_W bits and has two combinational read
//               ports and one write port. Register 0 is hardwired to zero.
//               With BYPASS=1, a write in the current cycle is forwarded to
//               any read port that addresses the same register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   Clk    in   1       clock; all state updates on the rising edge
//   Rst_n  in   1       synchronous active-low reset; clears registers 1..N-1
//   Ard1   in   ADDR_W  read address, port 1
//   Ard2   in   ADDR_W  read address, port 2
//   Awr    in   ADDR_W  write address
//   Din    in   DATA_W  write data
//   WrEn   in   1       write enable, sampled at the rising Clk edge
//   Dout1  out  DATA_W  read data, port 1 (combinational)
//   Dout2  out  DATA_W  read data, port 2 (combinational)
// ============================================================================
module register_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2
);

  localparam int C_NREGS = 2 ** ADDR_W;

  // Register 0 has no storage; the array starts at index 1.
  logic [DATA_W-1:0] regs_q [1:C_NREGS-1];

  // A write that will actually commit at the next edge.
  logic w_wr_act;
  logic w_fwd1;
  logic w_fwd2;

  assign w_wr_act = WrEn && Rst_n && (Awr != '0);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 1; i < C_NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_act) begin
      regs_q[Awr] <= Din;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign w_fwd1 = w_wr_act && (Ard1 == Awr);
      assign w_fwd2 = w_wr_act && (Ard2 == Awr);
    end else begin : g_no_bypass
      assign w_fwd1 = 1'b0;
      assign w_fwd2 = 1'b0;
    end
  endgenerate

  // The zero-address check comes first so that port N reads 0 for address 0
  // whatever the write port is doing. It also keeps the array index in range.
  always_comb begin
    Dout1 = '0;
    if (Ard1 != '0) begin
      if (w_fwd1) begin
        Dout1 = Din;
      end else begin
        Dout1 = regs_q[Ard1];
      end
    end
  end

  always_comb begin
    Dout2 = '0;
    if (Ard2 != '0) begin
      if (w_fwd2) begin
        Dout2 = Din;
      end else begin
        Dout2 = regs_q[Ard2];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_32x32
// Description : Self-checking bench for register_file_32x32. It runs a
//               write-first (BYPASS=1) instance and a read-old (BYPASS=0)
//               instance side by side on the same stimulus. A reference model
//               pushes the expected read data for each instance onto a
//               scoreboard as each cycle is driven. The bench pops those
//               entries and compares them with the outputs just before the
//               rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_32x32;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  Ard1, Ard2, Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic [31:0] Dout1b, Dout2b, Dout1n, Dout2n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] mem [0:31];
  bit          known = 1'b0;

  typedef struct {
    string       tag;
    int          port;   // 0/1: bypass DUT ports 1/2, 2/3: read-old DUT ports 1/2
    logic [31:0] exp;
  } sb_t;
  sb_t sb [$];

  register_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_dut_byp (
    .Clk(Clk), .Rst_n(Rst_n), .Ard1(Ard1), .Ard2(Ard2), .Awr(Awr),
    .Din(Din), .WrEn(WrEn), .Dout1(Dout1b), .Dout2(Dout2b)
  );

  register_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_dut_old (
    .Clk(Clk), .Rst_n(Rst_n), .Ard1(Ard1), .Ard2(Ard2), .Awr(Awr),
    .Din(Din), .WrEn(WrEn), .Dout1(Dout1n), .Dout2(Dout2n)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected value for one read port based on the inputs currently
  // driven. Reads of never-written storage before the first reset are skipped.
  task automatic push(input string tag, input int port, input logic [4:0] addr, input bit byp);
    sb_t e;
    e.tag  = tag;
    e.port = port;
    if (addr == 5'd0) begin
      e.exp = 32'h0;
    end else if (byp && WrEn && Rst_n && (Awr == addr)) begin
      e.exp = Din;
    end else if (known) begin
      e.exp = mem[addr];
    end else begin
      return;
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic rst_n, input logic we, input logic [4:0] aw,
                      input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2,
                      input string tag);
    sb_t         e;
    logic [31:0] obs;
    @(negedge Clk);
    Rst_n = rst_n; WrEn = we; Awr = aw; Din = d; Ard1 = a1; Ard2 = a2;
    push({tag, "/byp.d1"}, 0, a1, 1'b1);
    push({tag, "/byp.d2"}, 1, a2, 1'b1);
    push({tag, "/old.d1"}, 2, a1, 1'b0);
    push({tag, "/old.d2"}, 3, a2, 1'b0);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        0:       obs = Dout1b;
        1:       obs = Dout2b;
        2:       obs = Dout1n;
        default: obs = Dout2n;
      endcase
      chk(e.tag, obs, e.exp);
    end
    @(posedge Clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      known = 1'b1;
    end else if (we && aw != 5'd0) begin
      mem[aw] = d;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst_n = 1'b1; WrEn = 1'b0; Awr = '0; Din = '0; Ard1 = '0; Ard2 = '0;

    // Reset and zero register
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "reset");
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "post_reset_sweep");

    // Basic write and readback
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, "wr5");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd5");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd6, 5'd4, "rd_other");

    // Write to register 0
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr0");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, "rd0");

    // Same-cycle bypass vs read-old
    step(1'b1, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, "wr7a");
    step(1'b1, 1'b1, 5'd8, 32'h33333333, 5'd7, 5'd0, "wr8");
    step(1'b1, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd8, "byp7");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8, "rd7");
    step(1'b1, 1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd9, "byp_both");

    // Reset beats write
    step(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0, "wr3");
    step(1'b0, 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3, "rst_vs_wr");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, "rd_after_rst");

    // Full sweep: writes with reads in flight, then dual-port readback
    for (int i = 1; i < 32; i++)
      step(1'b1, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(31 - i), "sweep_wr");
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "sweep_rd");

    // Random traffic
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 49) != 0), 1'($urandom), 5'($urandom), $urandom,
           5'($urandom), 5'($urandom), "random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
